// File: rtl/jtag_sbus_master.sv
// rtl/jtag_sbus_master.sv - system-bus master driven by the debug module's sbcs/sbaddress/sbdata registers
module jtag_sbus_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sbaddress_i,
    input  logic        sbaddress_write_valid_i,
    input  logic        sbreadonaddr_i,
    input  logic        sbautoincrement_i,
    input  logic [2:0]  sbaccess_i,
    input  logic        sbreadondata_i,
    input  logic [31:0] sbdata_i,
    input  logic        sbdata_read_valid_i,
    input  logic        sbdata_write_valid_i,
    input  logic [2:0]  sberror_clear_i,
    output logic [31:0] sbaddress_o,
    output logic [31:0] sbdata_o,
    output logic        sbdata_valid_o,
    output logic        sbbusy_o,
    output logic [2:0]  sberror_o,
    output logic        master_req_o,
    input  logic        master_gnt_i,
    input  logic        master_rvalid_i,
    output logic        master_we_o,
    output logic [3:0]  master_be_o,
    output logic [31:0] master_addr_o,
    output logic [31:0] master_wdata_o,
    input  logic [31:0] master_rdata_i,
    input  logic        master_err_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LP_CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_sberror;
    logic [31:0]   r_sbdata;

    logic        w_wr_trig;
    logic        w_rdaddr_trig;
    logic        w_rd_trig;
    logic        w_size_err;
    logic        w_misaligned;
    logic        w_req;
    logic        w_expired;
    logic        w_in_wait;
    logic        w_ok;
    logic        w_rd_ok;
    logic [4:0]  w_byte_off;
    logic [31:0] w_rdata_shift;
    logic [31:0] w_rdata_sized;
    logic [3:0]  w_be_base;
    logic [31:0] w_incr;

    assign w_wr_trig     = sbdata_write_valid_i;
    assign w_rdaddr_trig = sbaddress_write_valid_i & sbreadonaddr_i;
    assign w_rd_trig     = w_rdaddr_trig | (sbdata_read_valid_i & sbreadondata_i);
    assign w_size_err    = sbaccess_i > 3'd2;
    assign w_misaligned  = ((sbaccess_i == 3'd1) && sbaddress_i[0]) ||
                           ((sbaccess_i == 3'd2) && (sbaddress_i[1:0] != 2'b00));

    // A read-on-address request must not be raised until the new address has been checked
    assign w_req     = (r_state == ST_WR_REQ) || ((r_state == ST_RD_REQ) && !w_misaligned);
    assign w_expired = (r_cnt == LP_CNT_MAX);
    assign w_in_wait = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
    assign w_ok      = w_in_wait && master_rvalid_i && !master_err_i;
    assign w_rd_ok   = w_ok && (r_state == ST_RD_WAIT);

    assign w_byte_off    = {sbaddress_i[1:0], 3'b000};
    assign w_rdata_shift = master_rdata_i >> w_byte_off;
    assign w_incr        = 32'd1 << sbaccess_i;

    always_comb begin
        w_rdata_sized = w_rdata_shift;
        w_be_base     = 4'b1111;
        case (sbaccess_i)
            3'd0: begin
                w_rdata_sized = {24'd0, w_rdata_shift[7:0]};
                w_be_base     = 4'b0001;
            end
            3'd1: begin
                w_rdata_sized = {16'd0, w_rdata_shift[15:0]};
                w_be_base     = 4'b0011;
            end
            default: ;
        endcase
    end

    assign master_req_o   = w_req;
    assign master_we_o    = (r_state == ST_WR_REQ);
    assign master_be_o    = w_req ? (w_be_base << sbaddress_i[1:0]) : 4'b0000;
    assign master_addr_o  = w_req ? {sbaddress_i[31:2], 2'b00} : 32'd0;
    assign master_wdata_o = (r_state == ST_WR_REQ) ? (sbdata_i << w_byte_off) : 32'd0;

    assign sbbusy_o       = r_busy;
    assign sberror_o      = r_sberror;
    assign sbdata_valid_o = w_rd_ok;
    assign sbdata_o       = w_rd_ok ? w_rdata_sized : r_sbdata;
    assign sbaddress_o    = (w_ok && sbautoincrement_i) ? sbaddress_i + w_incr : sbaddress_i;

    // Error assignments inside the case override the default clear, so a new error wins over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_sberror <= 3'd0;
            r_sbdata  <= 32'd0;
        end else begin
            r_sberror <= r_sberror & ~sberror_clear_i;
            r_cnt     <= r_cnt + CW'(1);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if ((r_sberror == 3'd0) && (w_wr_trig || w_rd_trig)) begin
                        if (w_size_err) begin
                            r_sberror <= 3'd4;
                        end else if (w_misaligned && (w_wr_trig || !w_rdaddr_trig)) begin
                            r_sberror <= 3'd3;
                        end else begin
                            r_state <= w_wr_trig ? ST_WR_REQ : ST_RD_REQ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RD_REQ, ST_WR_REQ: begin
                    if ((r_state == ST_RD_REQ) && w_misaligned) begin
                        r_sberror <= 3'd3;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else if (master_gnt_i) begin
                        r_state <= (r_state == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
                        r_cnt   <= '0;
                    end else if (w_expired) begin
                        r_sberror <= 3'd1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (master_rvalid_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (master_err_i) begin
                            r_sberror <= 3'd2;
                        end else if (r_state == ST_RD_WAIT) begin
                            r_sbdata <= w_rdata_sized;
                        end
                    end else if (w_expired) begin
                        r_sberror <= 3'd1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
